vec_mem_seq: RTL and testbench

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

---
 rtl/vec_mem_seq.sv | 147 ++++++++++++++
 tb/tb_vec_mem_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: issues an ELEMS-element vector load/store as a series of single-word memory requests.
// Define VEC_MEM_SEQ_ALIGN_CHECK_EN to abort misaligned transfers with err; otherwise base_addr[1:0] is ignored.
module vec_mem_seq #(
   parameter int ELEMS  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [32*ELEMS-1:0]   wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  vreg_we,
   output logic [2:0]            vreg_idx,
   output logic [31:0]           vreg_wdata,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

   localparam logic [2:0] LAST = 3'(ELEMS - 1);

   state_t              state_reg, state_next;
   logic [2:0]          idx_reg, idx_next;
   logic                store_reg, store_next;
   logic [ADDR_W-1:0]   base_reg, base_next;
   logic [32*ELEMS-1:0] data_reg, data_next;
   logic [31:0]         elem [8];
   logic                misaligned;

   // Pad the element view to 8 entries so the 3-bit counter can index it directly.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_elem
         if (gi < ELEMS) begin : g_live
            assign elem[gi] = data_reg[32*gi +: 32];
         end else begin : g_pad
            assign elem[gi] = 32'd0;
         end
      end
   endgenerate

`ifdef VEC_MEM_SEQ_ALIGN_CHECK_EN
   logic err_reg;

   assign misaligned = (base_addr[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (state_reg == IDLE && start) begin
         err_reg <= misaligned;
      end
   end

   assign err = (state_reg == FIN) && err_reg;
`else
   logic unused_base_lsbs;

   assign unused_base_lsbs = ^base_addr[1:0];
   assign misaligned       = 1'b0;
   assign err              = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= 3'd0;
         store_reg <= 1'b0;
         base_reg  <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         store_reg <= store_next;
         base_reg  <= base_next;
         data_reg  <= data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      store_next = store_reg;
      base_next  = base_reg;
      data_next  = data_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               store_next = is_store;
               base_next  = {base_addr[ADDR_W-1:2], 2'b00};
               data_next  = wdata;
               idx_next   = 3'd0;
               state_next = misaligned ? FIN : REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               if (!store_reg) begin
                  state_next = WAIT;
               end else if (idx_reg == LAST) begin
                  state_next = FIN;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               if (idx_reg == LAST) begin
                  state_next = FIN;
               end else begin
                  idx_next   = idx_reg + 3'd1;
                  state_next = REQ;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state so an asynchronous reset clears them at once.
   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == FIN);
   assign mem_req    = (state_reg == REQ);
   assign mem_we     = mem_req && store_reg;
   assign mem_addr   = mem_req ? base_reg + {{(ADDR_W-5){1'b0}}, idx_reg, 2'b00} : '0;
   assign mem_wdata  = mem_req ? elem[idx_reg] : 32'd0;
   assign vreg_we    = (state_reg == WAIT) && mem_rvalid;
   assign vreg_idx   = vreg_we ? idx_reg : 3'd0;
   assign vreg_wdata = vreg_we ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: randomized bench for vec_mem_seq with a transaction-level memory model and scoreboard.
// Covers VEC_MEM_SEQ_ALIGN_CHECK_EN in either build.
module tb_vec_mem_seq;
   localparam int ELEMS  = 4;
   localparam int ADDR_W = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                is_store = 1'b0;
   logic [31:0]         base_addr = '0;
   logic [32*ELEMS-1:0] wdata = '0;
   logic                busy, done, mem_req, mem_we, vreg_we, err;
   logic [31:0]         mem_addr, mem_wdata, vreg_wdata;
   logic [2:0]          vreg_idx;
   logic                mem_ready = 1'b0;
   logic                mem_rvalid = 1'b0;
   logic [31:0]         mem_rdata = '0;

   vec_mem_seq #(.ELEMS(ELEMS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .base_addr(base_addr),
      .wdata(wdata), .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .vreg_we(vreg_we),
      .vreg_idx(vreg_idx), .vreg_wdata(vreg_wdata), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // memory model knobs
   bit          rand_ready = 0;
   int          rand_delay_max = 0;
   int          fixed_delay = 0;
   bit          spurious = 0;
   int          stall_elem = -1;
   int          stall_left = 0;
   logic [31:0] fixed_q[$];
   logic [31:0] exp_fixed[ELEMS];

   // memory model state and transaction logs
   bit          pending = 0;
   int          wait_left = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] acc_addr[$];
   logic [31:0] acc_data[$];
   bit          acc_we[$];
   int          vr_idx[$];
   logic [31:0] vr_data[$];
   int          cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
   int          stab_err = 0, ovl_err = 0, acc_in_xfer = 0;
   bit          done_err = 0;
   bit          prev_stall = 0;
   bit          held_we = 0;
   logic [31:0] held_addr = '0, held_data = '0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
   endfunction

   // Each cycle: drive memory inputs at the falling edge, then observe the settled DUT outputs.
   always @(negedge clk) begin
      cyc++;
      if (pending) begin
         if (wait_left == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (fixed_q.size() > 0) ? fixed_q.pop_front() : mem_val(pend_addr);
            pending    = 0;
         end else begin
            wait_left--;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end
      end else begin
         mem_rvalid = spurious && ($urandom_range(0, 1) == 1);
         mem_rdata  = $urandom;
      end
      if (mem_req && acc_in_xfer == stall_elem && stall_left > 0) begin
         mem_ready = 1'b0;
         stall_left--;
      end else begin
         mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (prev_stall && !(mem_req && mem_addr == held_addr && mem_wdata == held_data && mem_we == held_we))
         stab_err++;
      if (mem_req && pending) ovl_err++;
      prev_stall = mem_req && !mem_ready;
      held_addr  = mem_addr;
      held_data  = mem_wdata;
      held_we    = mem_we;
      if (mem_req && mem_ready) begin
         acc_addr.push_back(mem_addr);
         acc_data.push_back(mem_wdata);
         acc_we.push_back(mem_we);
         acc_in_xfer++;
         if (!mem_we) begin
            pending   = 1;
            wait_left = (rand_delay_max > 0) ? $urandom_range(0, rand_delay_max) : fixed_delay;
            pend_addr = mem_addr;
         end
      end
      if (vreg_we) begin
         vr_idx.push_back(int'(vreg_idx));
         vr_data.push_back(vreg_wdata);
      end
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = err;
      end
   end

   task automatic knobs_default();
      rand_ready = 0; rand_delay_max = 0; fixed_delay = 0; spurious = 0;
      stall_elem = -1; stall_left = 0; fixed_q.delete();
   endtask

   task automatic launch(input bit st, input logic [31:0] b, input logic [32*ELEMS-1:0] wd,
                         output int c0);
      @(negedge clk); #3;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_at_start: busy=%b required 0", busy);
      end
      acc_addr.delete(); acc_data.delete(); acc_we.delete(); vr_idx.delete(); vr_data.delete();
      done_cnt = 0; busy_cnt = 0; stab_err = 0; ovl_err = 0; acc_in_xfer = 0;
      start = 1'b1; is_store = st; base_addr = b; wdata = wd;
      c0 = cyc;
      @(negedge clk); #3;
      start = 1'b0; is_store = ~st; base_addr = $urandom;
      for (int k = 0; k < ELEMS; k++) wdata[32*k +: 32] = $urandom;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done_cnt > 0) break;
         @(negedge clk); #2;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++; $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
      repeat (2) @(negedge clk);
      #3;
   endtask

   task automatic check_xfer(input string nm, input bit st, input logic [31:0] b,
                             input logic [32*ELEMS-1:0] wd, input bit use_fixed);
      logic [31:0] eff, a;
      bit exp_err;
      int n_exp;
      exp_err = 0;
      n_exp   = ELEMS;
      eff     = {b[31:2], 2'b00};
`ifdef VEC_MEM_SEQ_ALIGN_CHECK_EN
      if (b[1:0] != 2'b00) begin exp_err = 1; n_exp = 0; end
`endif
      checks++;
      if (acc_addr.size() != n_exp) begin
         errors++; $display("FAIL %s req_count: got %0d required %0d", nm, acc_addr.size(), n_exp);
      end else begin
         for (int k = 0; k < n_exp; k++) begin
            a = eff + 32'(4 * k);
            checks++;
            if (acc_addr[k] !== a || acc_we[k] !== st) begin
               errors++;
               $display("FAIL %s req%0d: addr=%h we=%b required addr=%h we=%b", nm, k, acc_addr[k], acc_we[k], a, st);
            end
            if (st) begin
               checks++;
               if (acc_data[k] !== wd[32*k +: 32]) begin
                  errors++; $display("FAIL %s wdata%0d: got %h required %h", nm, k, acc_data[k], wd[32*k +: 32]);
               end
            end
         end
      end
      checks++;
      if (vr_idx.size() != (st ? 0 : n_exp)) begin
         errors++; $display("FAIL %s vreg_count: got %0d required %0d", nm, vr_idx.size(), st ? 0 : n_exp);
      end else if (!st) begin
         for (int k = 0; k < n_exp; k++) begin
            a = use_fixed ? exp_fixed[k] : mem_val(eff + 32'(4 * k));
            checks++;
            if (vr_idx[k] != k || vr_data[k] !== a) begin
               errors++; $display("FAIL %s vreg%0d: idx=%0d data=%h required idx=%0d data=%h", nm, k, vr_idx[k], vr_data[k], k, a);
            end
         end
      end
      checks++;
      if (done_cnt != 1 || done_err !== exp_err) begin
         errors++; $display("FAIL %s done: pulses=%0d err=%b required 1 pulse err=%b", nm, done_cnt, done_err, exp_err);
      end
      checks++;
      if (stab_err != 0 || ovl_err != 0) begin
         errors++; $display("FAIL %s protocol: unstable=%0d overlap=%0d required 0/0", nm, stab_err, ovl_err);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, mem_req, mem_we, vreg_we, err} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: busy/done/req/we/vwe/err=%b required 000000", {busy, done, mem_req, mem_we, vreg_we, err});
      end
      checks++;
      if ({mem_addr, mem_wdata, vreg_idx, vreg_wdata} !== '0) begin
         errors++; $display("FAIL reset_data: addr=%h wdata=%h idx=%0d vdata=%h required 0", mem_addr, mem_wdata, vreg_idx, vreg_wdata);
      end
      repeat (3) @(negedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic test_store_basic();
      int c0;
      logic [32*ELEMS-1:0] wd;
      knobs_default();
      wd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      launch(1'b1, 32'h100, wd, c0);
      wait_done(50);
      check_xfer("store_basic", 1'b1, 32'h100, wd, 1'b0);
      checks++;
      if (done_cyc - c0 != ELEMS + 1 || busy_cnt != ELEMS + 1) begin
         errors++; $display("FAIL store_latency: done at +%0d busy %0d required +%0d busy %0d", done_cyc - c0, busy_cnt, ELEMS + 1, ELEMS + 1);
      end
   endtask

   task automatic test_load_basic();
      int c0;
      knobs_default();
      for (int k = 0; k < ELEMS; k++) begin
         exp_fixed[k] = 32'h11 * (k + 1);
         fixed_q.push_back(exp_fixed[k]);
      end
      launch(1'b0, 32'h200, '0, c0);
      wait_done(50);
      check_xfer("load_basic", 1'b0, 32'h200, '0, 1'b1);
      checks++;
      if (done_cyc - c0 != 2 * ELEMS + 1 || busy_cnt != 2 * ELEMS + 1) begin
         errors++; $display("FAIL load_latency: done at +%0d busy %0d required +%0d busy %0d", done_cyc - c0, busy_cnt, 2 * ELEMS + 1, 2 * ELEMS + 1);
      end
   endtask

   task automatic test_store_stall();
      int c0;
      logic [32*ELEMS-1:0] wd;
      knobs_default();
      stall_elem = 1; stall_left = 3;
      for (int k = 0; k < ELEMS; k++) wd[32*k +: 32] = $urandom;
      launch(1'b1, 32'h100, wd, c0);
      wait_done(50);
      check_xfer("store_stall", 1'b1, 32'h100, wd, 1'b0);
      checks++;
      if (done_cyc - c0 != ELEMS + 4) begin
         errors++; $display("FAIL stall_latency: done at +%0d required +%0d", done_cyc - c0, ELEMS + 4);
      end
   endtask

   task automatic test_ignore();
      int c0;
      logic [31:0] b;
      knobs_default();
      spurious = 1;
      b = 32'h0000_4440;
      launch(1'b0, b, '0, c0);
      for (int k = 0; k < 60 && done_cnt == 0; k++) begin
         start = $urandom_range(0, 1); is_store = $urandom; base_addr = $urandom;
         @(negedge clk); #3;
      end
      start = 1'b0;
      wait_done(50);
      check_xfer("ignore", 1'b0, b, '0, 1'b0);
      repeat (5) @(negedge clk);
      #3;
      checks++;
      if (acc_addr.size() != ELEMS || busy !== 1'b0) begin
         errors++; $display("FAIL ignore_after: reqs=%0d busy=%b required %0d and 0", acc_addr.size(), busy, ELEMS);
      end
      spurious = 0;
   endtask

   task automatic test_wrap();
      int c0;
      knobs_default();
      rand_ready = 1; rand_delay_max = 2;
      launch(1'b0, 32'hFFFF_FFF8, '0, c0);
      wait_done(100);
      check_xfer("wrap", 1'b0, 32'hFFFF_FFF8, '0, 1'b0);
   endtask

   task automatic test_align();
      int c0;
      logic [32*ELEMS-1:0] wd;
      knobs_default();
      for (int k = 0; k < ELEMS; k++) wd[32*k +: 32] = $urandom;
      launch(1'b1, 32'h102, wd, c0);
      wait_done(50);
      check_xfer("align", 1'b1, 32'h102, wd, 1'b0);
      checks++;
`ifdef VEC_MEM_SEQ_ALIGN_CHECK_EN
      if (done_cyc - c0 != 1) begin
         errors++; $display("FAIL align_latency: done at +%0d required +1", done_cyc - c0);
      end
`else
      if (done_cyc - c0 != ELEMS + 1) begin
         errors++; $display("FAIL align_latency: done at +%0d required +%0d", done_cyc - c0, ELEMS + 1);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int c0;
      logic [32*ELEMS-1:0] wd;
      knobs_default();
      fixed_delay = 3;
      launch(1'b0, 32'h300, '0, c0);
      for (int k = 0; k < 50 && acc_addr.size() < 3; k++) begin
         @(negedge clk); #3;
      end
      @(negedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, mem_req, mem_we, vreg_we, err, mem_addr, mem_wdata, vreg_idx, vreg_wdata} !== '0) begin
         errors++; $display("FAIL reset_mid_outputs: busy=%b req=%b addr=%h vwe=%b required all 0", busy, mem_req, mem_addr, vreg_we);
      end
      checks++;
      if (acc_addr.size() != 3 || vr_idx.size() != 2) begin
         errors++; $display("FAIL reset_mid_progress: reqs=%0d vregs=%0d required 3 and 2", acc_addr.size(), vr_idx.size());
      end
      @(negedge clk); #3;
      rst = 1'b0; pending = 0; wait_left = 0; fixed_delay = 0;
      repeat (4) @(negedge clk);
      #3;
      checks++;
      if (acc_addr.size() != 3 || vr_idx.size() != 2 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_quiet: reqs=%0d vregs=%0d busy=%b required 3, 2, 0", acc_addr.size(), vr_idx.size(), busy);
      end
      for (int k = 0; k < ELEMS; k++) wd[32*k +: 32] = $urandom;
      launch(1'b1, 32'h340, wd, c0);
      wait_done(50);
      check_xfer("after_reset", 1'b1, 32'h340, wd, 1'b0);
   endtask

   task automatic test_random();
      int c0;
      bit st;
      logic [31:0] b;
      logic [32*ELEMS-1:0] wd;
      knobs_default();
      rand_ready = 1; rand_delay_max = 2; spurious = 1;
      for (int t = 0; t < 40; t++) begin
         st = $urandom_range(0, 1);
         b  = $urandom;
         if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
         for (int k = 0; k < ELEMS; k++) wd[32*k +: 32] = $urandom;
         launch(st, b, wd, c0);
         wait_done(200);
         check_xfer("random", st, b, wd, 1'b0);
         $display("random xfer %0d: %s base=%h reqs=%0d vregs=%0d", t, st ? "store" : "load", b, acc_addr.size(), vr_idx.size());
      end
      knobs_default();
   endtask

   initial begin
      test_reset();
      test_store_basic();
      test_load_basic();
      test_store_stall();
      test_ignore();
      test_wrap();
      test_align();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
